// File: rtl/audio_pll_reset_ctrl.sv
// Reset/lock sequencer for the audio PLL: pulses the PLL reset, qualifies the
// synchronized lock flag, retries on timeout and holds the audio reset until lock is stable.
module audio_pll_reset_ctrl #(
    parameter int unsigned RST_CYCLES          = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       audio_rst,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                      RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStabilize,
        StRun,
        StFault
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_d;
    logic             r_lk_meta;
    logic             r_lk;
    logic             r_lock_lost;
    logic             w_lock_lost_d;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lk_meta <= 1'b0;
            r_lk      <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk      <= r_lk_meta;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_retry_d = r_retry;
        w_cnt_d   = r_cnt;

        unique case (r_state)
            StResetPll: begin
                if (r_cnt == RST_LAST) w_state_d = StWaitLock;
            end
            StWaitLock: begin
                // Lock beats a coincident timeout.
                if (r_lk) begin
                    w_state_d = StStabilize;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    if (r_retry < RETRY_MAX) begin
                        w_retry_d = r_retry + 4'd1;
                        w_state_d = StResetPll;
                    end else begin
                        w_state_d = StFault;
                    end
                end
            end
            StStabilize: begin
                if (!r_lk) begin
                    w_state_d = StWaitLock;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_d = StRun;
                    w_retry_d = 4'd0;
                end
            end
            StRun: begin
                if (!r_lk) w_state_d = StResetPll;
            end
            StFault: begin
            end
            default: w_state_d = StResetPll;
        endcase

        if (restart) begin
            w_state_d = StResetPll;
            w_retry_d = 4'd0;
        end

        // RUN and FAULT have no timed exit, so the counter idles there.
        if (restart || (w_state_d != r_state)) begin
            w_cnt_d = '0;
        end else if ((r_state == StResetPll) || (r_state == StWaitLock) ||
                     (r_state == StStabilize)) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end

        w_lock_lost_d = (r_state == StRun) && !r_lk && !restart;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= StResetPll;
            r_cnt       <= '0;
            r_retry     <= 4'd0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_retry     <= w_retry_d;
            r_lock_lost <= w_lock_lost_d;
        end
    end

    assign pll_rst     = (r_state == StResetPll) || (r_state == StFault);
    assign audio_rst   = (r_state != StRun);
    assign ready       = (r_state == StRun);
    assign fault       = (r_state == StFault);
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry;

endmodule
